// File: rtl/mux8_rr_collector.sv
// 8-to-1 round-robin collector: merges eight valid/ready lanes onto one registered
// output stream, tagging each word with its source lane on {s2,s1,s0}.
module mux8_rr_collector #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [7:0]          in_valid,
    input  logic [8*DATA_W-1:0] in_data,
    output logic [7:0]          in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                s0,
    output logic                s1,
    output logic                s2,
    output logic [CNT_W-1:0]    xfer_cnt
);

    logic [2:0]        ptr_q;
    logic [2:0]        sel_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [2:0]        grant_idx;
    logic              grant_found;
    logic              load_en;
    logic              accept;
    logic              xfer;

    // rst_n gates grants so in_ready stays low for the whole reset window
    assign load_en = rst_n & en & (~valid_q | out_ready);
    assign xfer    = valid_q & out_ready;
    assign accept  = |in_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= 8; i++) begin
            if (!grant_found && in_valid[3'(ptr_q + 3'(i))]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(ptr_q + 3'(i));
            end
        end
        in_ready = '0;
        if (load_en && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= 3'd7;
            sel_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                ptr_q   <= grant_idx;
                sel_q   <= grant_idx;
                valid_q <= 1'b1;
                data_q  <= in_data[32'(grant_idx) * DATA_W +: DATA_W];
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
            if (xfer) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign s0        = sel_q[0];
    assign s1        = sel_q[1];
    assign s2        = sel_q[2];
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux8_rr_collector.sv
// Directed bench for mux8_rr_collector: a reference grant model feeds a scoreboard
// of expected {lane, data} words that are checked as the output stream drains.
module tb_mux8_rr_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        s0, s1, s2;
    logic [15:0] xfer_cnt;

    logic [7:0]  in_ready_w4;
    logic        out_valid_w4;
    logic [7:0]  out_data_w4;
    logic        s0_w4, s1_w4, s2_w4;
    logic [3:0]  xfer_cnt_w4;

    logic [7:0]  lane_data [8];

    int          n_cmp = 0;
    int          n_err = 0;

    logic [2:0]  m_ptr;
    logic        m_valid;
    logic [15:0] m_cnt;
    logic [10:0] sb [$];

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = lane_data[k];
    end

    mux8_rr_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .xfer_cnt  (xfer_cnt)
    );

    mux8_rr_collector #(.DATA_W(8), .CNT_W(4)) dut_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_w4),
        .out_valid (out_valid_w4),
        .out_ready (out_ready),
        .out_data  (out_data_w4),
        .s0        (s0_w4),
        .s1        (s1_w4),
        .s2        (s2_w4),
        .xfer_cnt  (xfer_cnt_w4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 3'd7;
        m_valid = 1'b0;
        m_cnt   = '0;
        sb.delete();
    endtask

    // One clock: predict and check at the falling edge, then advance past the rising edge.
    task automatic cycle();
        logic       le;
        logic       found;
        logic       xf;
        logic [2:0] g;
        logic [7:0] exp_rdy;
        @(negedge clk);
        le    = rst_n && en && (!m_valid || out_ready);
        found = 1'b0;
        g     = '0;
        for (int i = 1; i <= 8; i++) begin
            if (!found && in_valid[3'(m_ptr + 3'(i))]) begin
                found = 1'b1;
                g     = 3'(m_ptr + 3'(i));
            end
        end
        exp_rdy = (le && found) ? (8'h01 << g) : 8'h00;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        check("xfer_cnt_w4", 32'(xfer_cnt_w4), 32'(m_cnt[3:0]));
        if (m_valid && sb.size() > 0) begin
            check("out_data", 32'(out_data), 32'(sb[0][7:0]));
            check("select", 32'({s2, s1, s0}), 32'(sb[0][10:8]));
        end
        xf = m_valid && out_ready;
        if (xf) begin
            void'(sb.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (le && found) begin
            sb.push_back({g, lane_data[g]});
            m_ptr   = g;
            m_valid = 1'b1;
        end else if (xf) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_select", 32'({s2, s1, s0}), 32'd0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid  = 8'h00;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) lane_data[k] = 8'(8'h10 * k + 8'h01);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single lane 0, immediate drain
        lane_data[0] = 8'hA5;
        in_valid     = 8'h01;
        out_ready    = 1'b1;
        cycle();
        check("t1_data", 32'(out_data), 32'h0000_00A5);
        check("t1_sel", 32'({s2, s1, s0}), 32'd0);
        in_valid = 8'h00;
        cycle();
        check("t1_cnt", 32'(xfer_cnt), 32'd1);

        // All lanes valid: back-to-back round-robin, 16 transfers
        do_reset();
        for (int k = 0; k < 8; k++) lane_data[k] = 8'(8'hC0 + k);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int n = 0; n < 17; n++) begin
            cycle();
            check("t2_sel", 32'({s2, s1, s0}), 32'(n % 8));
        end
        check("t2_cnt", 32'(xfer_cnt), 32'd16);

        // Lanes 2 and 7 alternate
        in_valid = 8'h84;
        for (int n = 0; n < 2; n++) begin
            cycle();
            check("t3_sel2", 32'({s2, s1, s0}), 32'd2);
            cycle();
            check("t3_sel7", 32'({s2, s1, s0}), 32'd7);
        end

        // Backpressure on a lane-5 word
        lane_data[5] = 8'h3C;
        in_valid     = 8'h20;
        cycle();
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle();
            check("t4_hold_data", 32'(out_data), 32'h0000_003C);
            check("t4_hold_sel", 32'({s2, s1, s0}), 32'd5);
        end
        out_ready = 1'b1;
        cycle();
        check("t4_next_sel", 32'({s2, s1, s0}), 32'd6);

        // en=0 drains the pending word then blocks grants
        out_ready = 1'b0;
        cycle();
        en = 1'b0;
        cycle();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) cycle();
        check("t5_idle", 32'(out_valid), 32'd0);
        en = 1'b1;
        cycle();
        cycle();

        // Narrow counter wrap, then reset mid-burst
        do_reset();
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int n = 0; n < 18; n++) cycle();
        check("t6_wrap", 32'(xfer_cnt_w4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("t6_first_sel", 32'({s2, s1, s0}), 32'd0);
        check("t6_first_valid", 32'(out_valid), 32'd1);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
